// File: rtl/serial_in_ctrl_pkg.sv
// Shared SAP-II serial-input definitions: controller state encoding and
// default frame/timeout sizing used by serial_in_ctrl.
package serial_in_ctrl_pkg;

  // Controller states; 3-bit encoding shared with SAP-II debug tooling.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECV    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_WAITLOW = 3'd4,
    ST_FULL    = 3'd5
  } state_e;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_TIMEOUT   = 255;

endpackage : serial_in_ctrl_pkg

// File: rtl/serial_in_ctrl.sv
// serial_in_ctrl: sequences the SAP-II serial input path. Takes bits from an
// external sender over a 4-phase valid/ack handshake, clears and shifts the
// input port 2 data register, raises byte_ready for input port 1 once a full
// frame is assembled, and gates Ei2 so the CPU reads each byte exactly once.
//
// Ports:
//   CLK, nCLR    clock, asynchronous active-low reset
//   rx_start     sender requests a frame (sampled in IDLE)
//   rx_valid     sender bit-valid (4-phase request)
//   rx_data      serial bit, stable while rx_valid is high
//   rd_req       Ei2 from the control word
//   rx_ack       handshake acknowledge to the sender
//   port_shift   one-cycle shift strobe to input port 2
//   port_serial  bit shifted into input port 2
//   port_nclr    active-low clear of input port 2 (combinational)
//   port_oe      gated Ei2 to input port 2 (combinational)
//   byte_ready   byte available, input port 1 bit 0
//   overrun      sticky: frame requested while a byte was pending
//   frame_err    sticky: frame aborted by inter-bit timeout
//   busy         controller is mid-frame
module serial_in_ctrl
  import serial_in_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic nCLR,
  input  logic rx_start,
  input  logic rx_valid,
  input  logic rx_data,
  input  logic rd_req,
  output logic rx_ack,
  output logic port_shift,
  output logic port_serial,
  output logic port_nclr,
  output logic port_oe,
  output logic byte_ready,
  output logic overrun,
  output logic frame_err,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               serial_q, serial_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_ack_q, rx_ack_d;
  logic               shift_q, shift_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  // Next-state, counter/timer and sticky-flag logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    serial_d    = serial_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_start) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          tmr_d       = '0;
          frame_err_d = 1'b0;
        end
      end

      ST_CLEAR: state_d = ST_RECV;

      ST_RECV: begin
        if (tmr_q == TMR_MAX) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          state_d  = ST_SHIFT;
          serial_d = rx_data;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_SHIFT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_WAITLOW;
      end

      // Hold ack until the sender drops valid (4-phase return to zero).
      ST_WAITLOW: begin
        if (tmr_q == TMR_MAX) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          tmr_d = tmr_q + TMR_W'(1);
        end else if (cnt_q == CNT_FULL) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_RECV;
          tmr_d   = '0;
        end
      end

      // A read wins over a new request, so a simultaneous start is not an overrun.
      ST_FULL: begin
        if (rd_req) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b0;
        end else if (rx_start) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state so they align with state_q.
  always_comb begin
    rx_ack_d = (state_d == ST_SHIFT) || (state_d == ST_WAITLOW);
    shift_d  = (state_d == ST_SHIFT);
    ready_d  = (state_d == ST_FULL);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_FULL);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      serial_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ack_q    <= 1'b0;
      shift_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      serial_q    <= serial_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_ack_q    <= rx_ack_d;
      shift_q     <= shift_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ack      = rx_ack_q;
  assign port_shift  = shift_q;
  assign port_serial = serial_q;
  assign byte_ready  = ready_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

  // Port is held clear during reset as well as in CLEAR.
  assign port_nclr = nCLR & (state_q != ST_CLEAR);
  // Ei2 only reaches the port when a complete byte is waiting.
  assign port_oe   = rd_req & (state_q == ST_FULL);

endmodule : serial_in_ctrl

// File: tb/tb_serial_in_ctrl.sv
// Directed bench for serial_in_ctrl with a behavioural model of input port 2.
// A second instance with TIMEOUT=4 shares all inputs for the timeout case.
module tb_serial_in_ctrl;

  logic CLK = 1'b0;
  logic nCLR;
  logic rx_start, rx_valid, rx_data, rd_req;

  logic rx_ack, port_shift, port_serial, port_nclr, port_oe;
  logic byte_ready, overrun, frame_err, busy;

  logic b_rx_ack, b_port_shift, b_port_serial, b_port_nclr, b_port_oe;
  logic b_byte_ready, b_overrun, b_frame_err, b_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int shift_cnt = 0;
  logic [7:0] port_reg;

  always #5 CLK = ~CLK;

  serial_in_ctrl #(.DATA_BITS(8), .TIMEOUT(255)) dut (
    .CLK(CLK), .nCLR(nCLR), .rx_start(rx_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rd_req(rd_req), .rx_ack(rx_ack),
    .port_shift(port_shift), .port_serial(port_serial), .port_nclr(port_nclr),
    .port_oe(port_oe), .byte_ready(byte_ready), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  serial_in_ctrl #(.DATA_BITS(8), .TIMEOUT(4)) dut_to (
    .CLK(CLK), .nCLR(nCLR), .rx_start(rx_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rd_req(rd_req), .rx_ack(b_rx_ack),
    .port_shift(b_port_shift), .port_serial(b_port_serial), .port_nclr(b_port_nclr),
    .port_oe(b_port_oe), .byte_ready(b_byte_ready), .overrun(b_overrun),
    .frame_err(b_frame_err), .busy(b_busy)
  );

  // Input port 2 model: insert at bit 7, shift right, async clear.
  always @(posedge CLK or negedge port_nclr) begin
    if (!port_nclr) port_reg <= 8'h00;
    else if (port_shift) port_reg <= {port_serial, port_reg[7:1]};
  end

  always @(posedge CLK) if (port_shift) shift_cnt <= shift_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One 4-phase bit; hold = extra cycles valid stays high after ack is seen.
  task automatic send_bit(input logic b, input int hold, output int ack_cyc, output int shifts);
    int  s0;
    bit  seen;
    s0 = shift_cnt;
    ack_cyc = 0;
    rx_data = b;
    rx_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rx_ack) seen = 1'b1;
    end
    check("ack_rise", 32'(seen), 32'd1);
    ack_cyc = 1;
    repeat (hold) begin
      tick();
      if (rx_ack) ack_cyc++;
    end
    rx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (!rx_ack) seen = 1'b1;
      else ack_cyc++;
    end
    check("ack_fall", 32'(seen), 32'd1);
    shifts = shift_cnt - s0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits, input int hold, input bit chk_ack);
    int ac, sh;
    for (int i = 0; i < nbits; i++) begin
      send_bit(v[i], hold, ac, sh);
      check("one_shift_per_bit", 32'(sh), 32'd1);
      if (chk_ack) check("ack_cycles", 32'(ac), 32'd5);
    end
  endtask

  // IDLE -> CLEAR -> RECV with the clear cycle checked.
  task automatic start_frame();
    rx_start = 1'b1;
    tick();
    check("clear_nclr", 32'(port_nclr), 32'd0);
    check("clear_busy", 32'(busy), 32'd1);
    rx_start = 1'b0;
    tick();
    check("recv_nclr", 32'(port_nclr), 32'd1);
  endtask

  initial begin
    int sc;
    nCLR = 1'b0; rx_start = 1'b0; rx_valid = 1'b0; rx_data = 1'b0; rd_req = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ack", 32'(rx_ack), 32'd0);
    check("rst_shift", 32'(port_shift), 32'd0);
    check("rst_serial", 32'(port_serial), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nclr", 32'(port_nclr), 32'd0);
    nCLR = 1'b1;
    #1;
    check("rel_nclr", 32'(port_nclr), 32'd1);
    tick();

    // Frame 0xA5, fast handshake
    sc = shift_cnt;
    start_frame();
    send_bits(8'hA5, 8, 0, 1'b0);
    check("a5_shifts", 32'(shift_cnt - sc), 32'd8);
    check("a5_ready", 32'(byte_ready), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    check("a5_oe_idle", 32'(port_oe), 32'd0);
    rd_req = 1'b1;
    #1;
    check("a5_oe", 32'(port_oe), 32'd1);
    check("a5_data", 32'(port_oe ? port_reg : 8'h00), 32'hA5);
    tick();
    rd_req = 1'b0;
    #1;
    check("a5_ready_fall", 32'(byte_ready), 32'd0);
    check("a5_oe_fall", 32'(port_oe), 32'd0);
    tick();

    // Frame 0x3C, sender holds valid 5 cycles per bit
    start_frame();
    send_bits(8'h3C, 8, 4, 1'b1);
    check("3c_ready", 32'(byte_ready), 32'd1);
    check("3c_overrun0", 32'(overrun), 32'd0);

    // Overrun: start while byte pending
    sc = shift_cnt;
    rx_start = 1'b1;
    tick();
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_ready", 32'(byte_ready), 32'd1);
    check("ovr_no_clear", 32'(port_nclr), 32'd1);
    check("ovr_busy", 32'(busy), 32'd0);
    tick();
    check("ovr_no_shift", 32'(shift_cnt - sc), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    rx_start = 1'b0;
    rd_req = 1'b1;
    #1;
    check("3c_data", 32'(port_oe ? port_reg : 8'h00), 32'h3C);
    tick();
    rd_req = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    check("3c_ready_fall", 32'(byte_ready), 32'd0);

    // Next frame starts after the read: 0x5A
    start_frame();
    send_bits(8'h5A, 8, 0, 1'b0);
    check("5a_ready", 32'(byte_ready), 32'd1);

    // Simultaneous read and start in FULL
    rd_req = 1'b1;
    rx_start = 1'b1;
    #1;
    check("sim_oe", 32'(port_oe), 32'd1);
    check("sim_data", 32'(port_oe ? port_reg : 8'h00), 32'h5A);
    tick();
    rd_req = 1'b0;
    check("sim_ready_fall", 32'(byte_ready), 32'd0);
    check("sim_no_overrun", 32'(overrun), 32'd0);
    check("sim_idle_busy", 32'(busy), 32'd0);
    check("sim_idle_nclr", 32'(port_nclr), 32'd1);
    tick();
    rx_start = 1'b0;
    check("sim_clear", 32'(port_nclr), 32'd0);
    check("sim_clear_busy", 32'(busy), 32'd1);
    tick();

    // rd_req during RECV is ignored; reset mid-frame
    rd_req = 1'b1;
    #1;
    check("recv_oe", 32'(port_oe), 32'd0);
    send_bits(8'h1F, 5, 0, 1'b0);
    check("recv_oe_late", 32'(port_oe), 32'd0);
    check("partial_reg", 32'(port_reg), 32'hF8);
    rd_req = 1'b0;
    nCLR = 1'b0;
    #1;
    check("mid_rst_nclr", 32'(port_nclr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(rx_ack), 32'd0);
    check("mid_rst_port", 32'(port_reg), 32'h00);
    tick();
    nCLR = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Timeout on the TIMEOUT=4 instance: stall after 3 bits
    start_frame();
    send_bits(8'h07, 3, 0, 1'b0);
    repeat (4) tick();
    check("to_not_yet", 32'(b_frame_err), 32'd0);
    check("to_busy", 32'(b_busy), 32'd1);
    tick();
    check("to_ferr", 32'(b_frame_err), 32'd1);
    check("to_idle", 32'(b_busy), 32'd0);
    check("to_ack", 32'(b_rx_ack), 32'd0);
    check("main_no_ferr", 32'(frame_err), 32'd0);
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    check("to_ferr_clr", 32'(b_frame_err), 32'd0);
    check("to_restart", 32'(b_port_nclr), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_serial_in_ctrl
